// File: rtl/uart_pkg.sv
// Shared UART types and defaults, common to the receiver, baud generator and transmitter.
// Latency: none (types and constants only).
// Backpressure: none.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int OVERSAMPLE_DEF = 8;
    localparam int DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: oversample tick and serial line in, received byte and status strobes out.
// Latency: none (wiring only).
// Backpressure: none; every strobe is a single-cycle pulse that must be taken when it appears.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 parity_err;

    // master is the receiver, slave is the logic feeding ticks/line and consuming bytes
    modport master (
        input  baud_tick, rx,
        output rx_data, rx_done, rx_busy, frame_err, parity_err
    );

    modport slave (
        output baud_tick, rx,
        input  rx_data, rx_done, rx_busy, frame_err, parity_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
// Latency: 2 clk.
// Backpressure: none.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8x-oversampled UART receiver, LSB first; optional parity bit with UART_RX_PARITY_EN defined.
// Latency: strobes one clk after the stop-bit sample, about 9.5 bit periods from start edge (10.5 with parity).
// Backpressure: none; rx_done/frame_err/parity_err are single-cycle pulses, rx_data holds until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic clk,
    input  logic reset,
    uart_rx_if.master u
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic                 rx_s;
    logic                 rx_q;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_done_q, rx_done_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_mis_q, par_mis_d;
    logic                 parity_err_q, parity_err_d;
`endif

    sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .d     (u.rx),
        .q     (rx_s)
    );

    logic start_edge, mid_start, mid_bit, last_bit;
    assign start_edge = rx_q & ~rx_s;
    assign mid_start  = (tick_cnt_q == TICK_HALF);
    assign mid_bit    = (tick_cnt_q == TICK_FULL);
    assign last_bit   = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q         <= 1'b1;
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            rx_data_q    <= '0;
            rx_done_q    <= 1'b0;
            rx_busy_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_mis_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_q         <= rx_s;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            rx_busy_q    <= rx_busy_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_mis_q    <= par_mis_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Edge detection in IDLE runs every clk; everything else waits for baud_tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start_edge)                          state_d = START;
            START:  if (u.baud_tick && mid_start)            state_d = rx_s ? IDLE : DATA;
            DATA:   if (u.baud_tick && mid_bit && last_bit)  state_d = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY: if (u.baud_tick && mid_bit)              state_d = STOP;
`endif
            STOP:   if (u.baud_tick && mid_bit)              state_d = IDLE;
            default:                                         state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_mis_d    = par_mis_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (start_edge) tick_cnt_d = '0;
            START: if (u.baud_tick) begin
                if (mid_start) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                    par_mis_d  = 1'b0;
`endif
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            DATA: if (u.baud_tick) begin
                if (mid_bit) begin
                    shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                    tick_cnt_d = '0;
                    if (!last_bit) bit_cnt_d = bit_cnt_q + BW'(1);
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (u.baud_tick) begin
                if (mid_bit) begin
                    par_mis_d  = (^{shreg_q, rx_s}) ^ PARITY_ODD;
                    tick_cnt_d = '0;
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
`endif
            STOP: if (u.baud_tick) begin
                if (mid_bit) begin
                    tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_mis_q;
                    if (!rx_s)          frame_err_d = 1'b1;
                    else if (!par_mis_q) begin
                        rx_data_d = shreg_q;
                        rx_done_d = 1'b1;
                    end
`else
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else begin
                        rx_data_d = shreg_q;
                        rx_done_d = 1'b1;
                    end
`endif
                end else begin
                    tick_cnt_d = tick_cnt_q + TW'(1);
                end
            end
            default: tick_cnt_d = '0;
        endcase
        rx_busy_d = (state_d != IDLE);
    end

    assign u.rx_data   = rx_data_q;
    assign u.rx_done   = rx_done_q;
    assign u.rx_busy   = rx_busy_q;
    assign u.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign u.parity_err = parity_err_q;
`else
    // Parity sense is irrelevant here; it is referenced so both builds share one parameter list.
    assign u.parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized frame stimulus for uart_rx, checked against a frame-level reference model.
// The tick divider is shortened from the 9600-baud value so the whole run stays small.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int  TICK_DIV   = 16;
    localparam int  BIT_CLK    = TICK_DIV * OVERSAMPLE_DEF;
    localparam bit  PARITY_ODD = 1'b0;

    logic clk;
    logic reset;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OVERSAMPLE_DEF),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .u     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        bus.baud_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            bus.baud_tick = 1'b1;
            @(negedge clk);
            bus.baud_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.rx_done) begin
            done_cnt++;
            got_q.push_back(bus.rx_data);
        end
        if (bus.frame_err)  ferr_cnt++;
        if (bus.parity_err) perr_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        bus.rx = v;
        repeat (BIT_CLK - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        repeat (n) drive_bit(1'b1);
    endtask

    // Correct parity bit for a byte under the configured sense.
    function automatic logic good_par(input logic [7:0] d);
        return ($countones(d) % 2 == 1) ^ PARITY_ODD;
    endfunction

    function automatic bit parity_bad(input logic [7:0] d, input logic par);
`ifdef UART_RX_PARITY_EN
        return (par != good_par(d));
`else
        return (par != par);
`endif
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    // Sends one frame and checks the outcome predicted from the frame contents alone.
    task automatic frame_test(input string tag, input logic [7:0] d, input logic par, input logic stop);
        int d0, f0, p0;
        bit bad, ok;
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(d, par, stop);
        idle_bits(2);
        bad = parity_bad(d, par);
        ok  = stop && !bad;
        if (ok) exp_data = d;
        check({tag, "_done"}, done_cnt - d0, ok ? 1 : 0);
        check({tag, "_ferr"}, ferr_cnt - f0, stop ? 0 : 1);
        check({tag, "_perr"}, perr_cnt - p0, bad ? 1 : 0);
        check({tag, "_data"}, bus.rx_data, exp_data);
        check({tag, "_busy"}, bus.rx_busy, 0);
    endtask

    initial begin
        int d0, f0, p0, base;
        logic [7:0] rd;
        logic rs, rp;

        reset  = 1'b1;
        bus.rx = 1'b1;
        exp_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_data", bus.rx_data, 0);
        check("rst_done", bus.rx_done, 0);
        check("rst_busy", bus.rx_busy, 0);
        check("rst_ferr", bus.frame_err, 0);
        check("rst_perr", bus.parity_err, 0);
        reset = 1'b0;
        idle_bits(2);

        frame_test("a5", 8'hA5, good_par(8'hA5), 1'b1);

        // Short low pulse that is gone by the mid-start sample.
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (TICK_DIV + 4) @(negedge clk);
        check("glitch_busy_hi", bus.rx_busy, 1);
        repeat (TICK_DIV - 4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (4 * TICK_DIV) @(negedge clk);
        check("glitch_busy_lo", bus.rx_busy, 0);
        idle_bits(1);
        check("glitch_strobes", (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
        check("glitch_data", bus.rx_data, exp_data);

        // Bad stop bit, then the line stays low like a break.
        d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        send_frame(8'h3C, good_par(8'h3C), 1'b0);
        check("ferr_pulse", ferr_cnt - f0, 1);
        check("ferr_done", done_cnt - d0, 0);
        repeat (20) drive_bit(1'b0);
        check("break_busy", bus.rx_busy, 0);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_data", bus.rx_data, exp_data);
        idle_bits(2);
        check("break_done", done_cnt - d0, 0);

        // Back-to-back frames with no idle gap.
        d0 = done_cnt; base = got_q.size();
        send_frame(8'h00, good_par(8'h00), 1'b1);
        send_frame(8'hFF, good_par(8'hFF), 1'b1);
        idle_bits(2);
        check("b2b_count", done_cnt - d0, 2);
        if (got_q.size() >= base + 2) begin
            check("b2b_first", got_q[base], 8'h00);
            check("b2b_second", got_q[base + 1], 8'hFF);
        end else begin
            check("b2b_queue", got_q.size() - base, 2);
        end
        exp_data = 8'hFF;
        check("b2b_data", bus.rx_data, exp_data);

        // Reset in the middle of bit 3 of 0x55.
        d0 = done_cnt; f0 = ferr_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(rd_bit(8'h55, i));
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_data", bus.rx_data, 0);
        check("mid_rst_busy", bus.rx_busy, 0);
        check("mid_rst_done", bus.rx_done, 0);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        exp_data = 8'h00;
        idle_bits(2);
        check("post_rst_strobes", (done_cnt - d0) + (ferr_cnt - f0), 0);
        check("post_rst_busy", bus.rx_busy, 0);
        frame_test("x81", 8'h81, good_par(8'h81), 1'b1);

`ifdef UART_RX_PARITY_EN
        frame_test("par_ok", 8'h07, 1'b1, 1'b1);
        frame_test("par_bad", 8'h07, 1'b0, 1'b1);
`endif

        for (int k = 0; k < 8; k++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rp = ($urandom_range(0, 2) == 0) ? ~good_par(rd) : good_par(rd);
            frame_test("rand", rd, rp, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    function automatic logic rd_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction

endmodule
